// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V definitions: immediate format codes, base
//                opcodes and the per-format immediate bit-position mask.
//                Common to the immediate decoder and the immediate encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Immediate format selector, identical encoding on decode and encode side
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Instruction bit positions occupied by the immediate of each format.
    // Unknown formats own no bits, so the base instruction passes through.
    function automatic logic [31:0] imm_field_mask(input logic [2:0] src);
        logic [31:0] mask;
        case (src)
            IMM_I:   mask = 32'hFFF0_0000;
            IMM_S:   mask = 32'hFE00_0F80;
            IMM_B:   mask = 32'hFE00_0F80;
            IMM_J:   mask = 32'hFFFF_F000;
            IMM_U:   mask = 32'hFFFF_F000;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pack
//  Description : Combinational immediate packer. Scatters the immediate into
//                the instruction word (inverse of the sign-extending decoder)
//                and, when IMM_RANGE_CHECK_EN is defined, flags immediates
//                that the selected format cannot represent.
//  Config      : IMM_RANGE_CHECK_EN - adds the err output and range checks
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
    import riscv_pkg::*;
#(
    parameter int N_Bits = 32   // only 32 is meaningful
) (
    input  logic [2:0]        imm_src,
    input  logic [N_Bits-1:0] imm,
    input  logic [N_Bits-1:0] base_instr,
    output logic [N_Bits-1:0] instr
`ifdef IMM_RANGE_CHECK_EN
    ,
    output logic              err
`endif
);

    logic [N_Bits-1:0] field;

    // Scatter immediate bits into their instruction positions; all else zero
    always_comb begin
        field = '0;
        case (imm_src)
            IMM_I: field[31:20] = imm[11:0];
            IMM_S: begin
                field[31:25] = imm[11:5];
                field[11:7]  = imm[4:0];
            end
            IMM_B: begin
                field[31]    = imm[12];
                field[30:25] = imm[10:5];
                field[11:8]  = imm[4:1];
                field[7]     = imm[11];
            end
            IMM_J: begin
                field[31]    = imm[20];
                field[30:21] = imm[10:1];
                field[20]    = imm[11];
                field[19:12] = imm[19:12];
            end
            IMM_U: field[31:12] = imm[31:12];
            default: field = '0;
        endcase
    end

    assign instr = (base_instr & ~imm_field_mask(imm_src)) | field;

`ifdef IMM_RANGE_CHECK_EN
    // A value fits a k-bit signed field when all bits from k-1 upward agree
    logic fits12;
    logic fits13;
    logic fits21;

    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Representability check for the selected format
    always_comb begin
        err = 1'b0;
        case (imm_src)
            IMM_I:   err = ~fits12;
            IMM_S:   err = ~fits12;
            IMM_B:   err = ~fits13 | imm[0];
            IMM_J:   err = ~fits21 | imm[0];
            IMM_U:   err = |imm[11:0];
            default: err = 1'b1;
        endcase
    end
`endif

endmodule : imm_pack
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Single-stage registered RISC-V immediate encoder with a
//                valid/ready handshake on both sides. Packing is done in
//                imm_pack; this level holds the output register, the
//                handshake and the saturating error counter.
//  Config      : IMM_RANGE_CHECK_EN - enables out_err and err_count; when
//                undefined both are tied to zero and no counter exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int N_Bits = 32   // only 32 is meaningful
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [N_Bits-1:0] imm,
    input  logic [N_Bits-1:0] base_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_Bits-1:0] instr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    logic [N_Bits-1:0] pack_instr;
    logic              accept;

    // The stage can take a new request whenever its slot is empty or leaving
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

`ifdef IMM_RANGE_CHECK_EN
    logic       pack_err;
    logic [7:0] err_cnt;

    imm_pack #(.N_Bits(N_Bits)) u_pack (
        .imm_src    (imm_src),
        .imm        (imm),
        .base_instr (base_instr),
        .instr      (pack_instr),
        .err        (pack_err)
    );

    // Error flag travels with the registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (accept) begin
            out_err <= pack_err;
        end
    end

    // Count accepted requests that carry an error, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (accept && pack_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_count = err_cnt;
`else
    imm_pack #(.N_Bits(N_Bits)) u_pack (
        .imm_src    (imm_src),
        .imm        (imm),
        .base_instr (base_instr),
        .instr      (pack_instr)
    );

    assign out_err   = 1'b0;
    assign err_count = 8'd0;
`endif

    // Output valid: set on accept, cleared when drained with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Result register only loads on accept, so it holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
        end else if (accept) begin
            instr <= pack_instr;
        end
    end

endmodule : imm_encoder
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Self-checking bench for imm_encoder. Table of vectors with
//                hand-derived encodings, scoreboard queue filled on input
//                accept and drained on output accept, plus hand sequences
//                for latency, back-pressure, reset and counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        err;        // expected flag when range checking exists
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_src = 3'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] base_instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instr;
    logic        out_err;
    logic [7:0]  err_count;

    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 0;       // 0: always ready, 1: random, 2: held low
    logic acc_flag = 1'b0;
    exp_t cur_exp;
    exp_t sb[$];
    int   cnt_model = 0;
    vec_t vecs[17];

    imm_encoder #(.N_Bits(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_src    (imm_src),
        .imm        (imm),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b,
                                input logic [31:0] e, input logic er);
        vec_t v;
        v.src = s; v.imm = i; v.base = b; v.exp_instr = e; v.err = er;
        return v;
    endfunction

    // Consumer-side ready generator
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                    out_ready = 1'b0;
    end

    // Scoreboard: push on input accept, pop and compare on output accept
    initial forever begin
        @(negedge clk);
        acc_flag = rst_n && in_valid && in_ready;
        if (acc_flag) begin
            sb.push_back(cur_exp);
            if (cur_exp.err && cnt_model != 255) cnt_model++;
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got instr 0x%08h, expected no output", instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("instr", instr, e.instr);
                chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            end
        end
    end

    // Present one request and hold it until accepted (bounded)
    task automatic send(input vec_t v);
        int  n;
        bit  got;
        imm_src     = v.src;
        imm         = v.imm;
        base_instr  = v.base;
        cur_exp.instr = v.exp_instr;
        cur_exp.err   = CHK & v.err;
        in_valid    = 1'b1;
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(posedge clk);
            n++;
            if (acc_flag) got = 1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = mk(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        vecs[1]  = mk(3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        vecs[2]  = mk(3'b001, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 1'b0);
        vecs[3]  = mk(3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        vecs[4]  = mk(3'b100, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
        vecs[5]  = mk(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        vecs[6]  = mk(3'b011, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1);
        vecs[7]  = mk(3'b011, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
        vecs[8]  = mk(3'b010, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1);
        vecs[9]  = mk(3'b101, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1);
        vecs[10] = mk(3'b000, 32'h0000_0005, 32'hFFF0_0093, 32'h0050_0093, 1'b0);
        vecs[11] = mk(3'b001, 32'hFFFF_F800, 32'h00B5_2023, 32'h80B5_2023, 1'b0);
        vecs[12] = mk(3'b100, 32'hFFFF_F000, 32'h0000_0017, 32'hFFFF_F017, 1'b0);
        vecs[13] = mk(3'b010, 32'hFFFF_FFFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0);
        vecs[14] = mk(3'b001, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1);
        vecs[15] = mk(3'b010, 32'h0000_0002, 32'h0000_0063, 32'h0000_0163, 1'b0);
        vecs[16] = mk(3'b010, 32'h0000_0001, 32'h0000_0063, 32'h0000_0063, 1'b1);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        idle(1);

        // One-cycle latency: not valid before the accepting edge, valid after
        chk("pre_accept_valid", {31'd0, out_valid}, 32'd0);
        send(vecs[0]);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        send(vecs[4]);
        idle(3);
        chk("err_count_one", {24'd0, err_count}, CHK ? 32'd1 : 32'd0);

        // Back-to-back, always ready: one result per cycle, in order
        for (int i = 0; i < 17; i++) send(vecs[i]);
        idle(3);
        chk("err_count_table", {24'd0, err_count}, 32'(CHK ? cnt_model : 0));

        // Random back-pressure, same vectors
        rdy_mode = 1;
        for (int i = 16; i >= 0; i--) send(vecs[i]);
        rdy_mode = 0;
        idle(4);

        // Stall: out_ready held low for 5 cycles with a result waiting
        rdy_mode = 2;
        out_ready = 1'b0;
        send(vecs[1]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_instr", instr, 32'hFE00_0EE3);
        end
        rdy_mode = 0;
        idle(3);

        // Reset while a result is held: dropped immediately, never emitted
        rdy_mode = 2;
        out_ready = 1'b0;
        send(vecs[3]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_err_count", {24'd0, err_count}, 32'd0);
        sb.delete();
        cnt_model = 0;
        rdy_mode = 0;
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(5);
        chk("midrst_no_output", {31'd0, out_valid}, 32'd0);

        // Counter saturation: 300 errored U requests
        v = mk(3'b100, 32'h0000_0001, 32'h0000_0037, 32'h0000_0037, 1'b1);
        for (int i = 0; i < 300; i++) send(v);
        idle(3);
        chk("err_count_sat", {24'd0, err_count}, CHK ? 32'd255 : 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_imm_encoder
`default_nettype wire

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter N_Bits, default 32, instruction/immediate width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-006 SHALL have port imm_src  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-007 SHALL have port imm  input  N_Bits  full-width immediate value to encode.
REQ-008 SHALL have port base_instr  input  N_Bits  instruction with opcode/rd/rs/funct fields; immediate bit positions ignored.
REQ-009 SHALL have port out_valid  output  1  encoded instruction valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-011 SHALL have port instr  output  N_Bits  encoded instruction.
REQ-012 SHALL have port out_err  output  1  immediate not representable in selected format (qualified by out_valid).
REQ-013 SHALL have port err_count  output  8  saturating count of accepted requests flagged out_err.

Function
REQ-014 SHALL place immediate bits as the inverse of the sign-extension decoder: I instr[31:20]=imm[11:0]; S instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; B instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; J instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; U instr[31:12]=imm[31:12].
REQ-015 SHALL take all non-immediate bit positions of instr from base_instr.
REQ-016 SHALL flag out_err when: I/S imm is not the sign-extension of imm[11:0]; B imm not sign-extension of imm[12:0] or imm[0]=1; J imm not sign-extension of imm[20:0] or imm[0]=1; U imm[11:0]!=0.
REQ-017 SHALL, for imm_src 101-111, output instr=base_instr with out_err=1.
REQ-018 SHALL still emit the truncated encoding when out_err=1.
REQ-019 SHALL be a single registered stage: latency 1 cycle from accept to out_valid.
REQ-020 SHALL drive in_ready = !out_valid | out_ready (full throughput, one request per cycle).
REQ-021 SHALL hold instr/out_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous output accept and input accept, load the new result with out_valid remaining 1.
REQ-023 SHALL clear out_valid after output accept with no new input accept.
REQ-024 SHALL increment err_count on each input accept whose result has out_err=1, saturating at 255.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear out_valid, instr, out_err, err_count to 0.
REQ-026 SHALL discard any held result when reset asserts mid-transaction; none is emitted after release.
REQ-027 SHALL assert in_ready in the first cycle after reset release.

Configuration
REQ-028 SHALL, with macro IMM_RANGE_CHECK_EN defined, implement REQ-016, REQ-017 error flagging and REQ-024 counting.
REQ-029 SHALL, without IMM_RANGE_CHECK_EN, tie out_err=0 and err_count=0 with no counter registers; encoding unchanged.

Structure
REQ-030 SHALL take imm_src format codes (enum, 3-bit) and opcode constants from shared package riscv_pkg, common with the immediate decoder.
REQ-031 SHALL place combinational packing and range check in sub-module imm_pack; imm_encoder holds the register stage, handshake and counter.

Verification
REQ-032 SHALL cover: I, imm=0xFFFFFFFF, base=0x00000013 -> instr=0xFFF00013, out_err=0, one cycle later.
REQ-033 SHALL cover: B, imm=0xFFFFFFFC, base=0x00000063 -> instr=0xFE000EE3; S, imm=8, base=0x00002023 -> 0x00002423.
REQ-034 SHALL cover: U, imm=0x12345000, base=0x00000037 -> 0x12345037; U imm=0x12345001 -> out_err=1, err_count=1.
REQ-035 SHALL cover: I imm=0x00000800 and J imm=3 -> out_err=1 each; 300 errored requests -> err_count=255.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, instr stable; back-to-back requests with out_ready=1 -> one result per cycle, order preserved.
REQ-037 SHALL cover: rst_n low while out_valid=1 -> out_valid=0 immediately, no result emitted after release.
